// File: rtl/branch_predictor.sv
// Gshare direction predictor with a direct-mapped BTB.
// Combinational lookup for fetch; trained on resolved branches from execute.
module branch_predictor #(
    parameter int DBITS        = 32,
    parameter int BHR_BITS     = 8,
    parameter int BTB_IDX_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DBITS-1:0]    fe_pc,
    output logic                pred_taken,
    output logic [DBITS-1:0]    pred_target,
    output logic [BHR_BITS-1:0] pred_bhr,
    input  logic                upd_valid,
    input  logic                upd_taken,
    input  logic [DBITS-1:0]    upd_target,
    input  logic [BHR_BITS-1:0] upd_bhr,
    input  logic [DBITS-1:0]    upd_pc
);

    localparam int PHT_N    = 1 << BHR_BITS;
    localparam int BTB_N    = 1 << BTB_IDX_BITS;
    localparam int TAG_BITS = DBITS - BTB_IDX_BITS - 2;

    logic [1:0]          pht        [PHT_N];
    logic [BHR_BITS-1:0] bhr;
    logic                btb_valid  [BTB_N];
    logic [TAG_BITS-1:0] btb_tag    [BTB_N];
    logic [DBITS-1:0]    btb_target [BTB_N];

    logic [BHR_BITS-1:0]     lk_pht_idx;
    logic [BTB_IDX_BITS-1:0] lk_btb_idx;
    logic [TAG_BITS-1:0]     lk_tag;
    logic                    lk_hit;
    logic [DBITS-1:0]        lk_fall;

    logic [BHR_BITS-1:0]     up_pht_idx;
    logic [BTB_IDX_BITS-1:0] up_btb_idx;
    logic [TAG_BITS-1:0]     up_tag;
    logic                    up_en;

    function automatic logic [1:0] sat_next(
        input logic [1:0] cnt,
        input logic       taken
    );
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != 2'b11) begin
            nxt = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            nxt = cnt - 2'b01;
        end
        return nxt;
    endfunction

    // Lookup path: reads pre-update state, no bypass from the update port.
    always_comb begin
        lk_pht_idx = fe_pc[BHR_BITS+1:2] ^ bhr;
        lk_btb_idx = fe_pc[BTB_IDX_BITS+1:2];
        lk_tag     = fe_pc[DBITS-1:BTB_IDX_BITS+2];
        lk_hit     = btb_valid[lk_btb_idx] && (btb_tag[lk_btb_idx] == lk_tag);
        lk_fall    = fe_pc + DBITS'(4);
        pred_taken = lk_hit && pht[lk_pht_idx][1];
        pred_bhr   = bhr;
        if (pred_taken) begin
            pred_target = btb_target[lk_btb_idx];
        end else begin
            pred_target = lk_fall;
        end
    end

    always_comb begin
        up_pht_idx = upd_pc[BHR_BITS+1:2] ^ upd_bhr;
        up_btb_idx = upd_pc[BTB_IDX_BITS+1:2];
        up_tag     = upd_pc[DBITS-1:BTB_IDX_BITS+2];
        up_en      = upd_valid && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bhr <= '0;
        end else if (upd_valid) begin
            bhr <= {bhr[BHR_BITS-2:0], upd_taken};
        end
    end

    // Counters come out of reset weakly not-taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            pht[up_pht_idx] <= sat_next(pht[up_pht_idx], upd_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid[i] <= 1'b0;
            end
        end else if (upd_valid && upd_taken) begin
            btb_valid[up_btb_idx] <= 1'b1;
        end
    end

    // Tag and target need no reset; the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (up_en && upd_taken) begin
            btb_tag[up_btb_idx]    <= up_tag;
            btb_target[up_btb_idx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table then a model-checked
// random phase, both compared through an expected-result queue.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] fe_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_bhr;
    logic        upd_valid;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [7:0]  upd_bhr;
    logic [31:0] upd_pc;

    branch_predictor #(
        .DBITS(32),
        .BHR_BITS(8),
        .BTB_IDX_BITS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fe_pc(fe_pc),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .pred_bhr(pred_bhr),
        .upd_valid(upd_valid),
        .upd_taken(upd_taken),
        .upd_target(upd_target),
        .upd_bhr(upd_bhr),
        .upd_pc(upd_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [31:0] fe;
        bit          uv;
        bit          ut;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic [7:0]  ubhr;
        bit          chk;
        bit          et;
        logic [31:0] etgt;
        logic [7:0]  ebhr;
    } vec_t;

    typedef struct {
        int          id;
        bit          t;
        logic [31:0] tgt;
        logic [7:0]  bhr;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state used by the random phase.
    logic [1:0]  m_pht [256];
    logic [7:0]  m_bhr;
    bit          m_v   [16];
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];

    function automatic vec_t mk(bit rst, logic [31:0] fe, bit uv, bit ut,
                                logic [31:0] upc, logic [31:0] utgt,
                                logic [7:0] ubhr, bit chk, bit et,
                                logic [31:0] etgt, logic [7:0] ebhr);
        vec_t v;
        v.rst = rst; v.fe = fe; v.uv = uv; v.ut = ut;
        v.upc = upc; v.utgt = utgt; v.ubhr = ubhr; v.chk = chk;
        v.et = et; v.etgt = etgt; v.ebhr = ebhr;
        return v;
    endfunction

    function automatic vec_t lk(logic [31:0] fe, bit et,
                                logic [31:0] etgt, logic [7:0] ebhr);
        return mk(0, fe, 0, 0, 0, 0, 0, 1, et, etgt, ebhr);
    endfunction

    function automatic vec_t up(logic [31:0] fe, bit ut, logic [31:0] upc,
                                logic [31:0] utgt, logic [7:0] ubhr, bit et,
                                logic [31:0] etgt, logic [7:0] ebhr);
        return mk(0, fe, 1, ut, upc, utgt, ubhr, 1, et, etgt, ebhr);
    endfunction

    function automatic exp_t model_lookup(int id, logic [31:0] fe);
        exp_t        e;
        logic [7:0]  idx;
        logic [3:0]  bi;
        bit          hit;
        idx   = fe[9:2] ^ m_bhr;
        bi    = fe[5:2];
        hit   = m_v[bi] && (m_tag[bi] == fe[31:6]);
        e.id  = id;
        e.t   = hit && m_pht[idx][1];
        e.tgt = e.t ? m_tgt[bi] : fe + 32'd4;
        e.bhr = m_bhr;
        return e;
    endfunction

    task automatic model_update(vec_t v);
        logic [7:0] idx;
        logic [3:0] bi;
        if (v.rst) begin
            m_bhr = 8'h00;
            for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
            for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
        end else if (v.uv) begin
            idx = v.upc[9:2] ^ v.ubhr;
            bi  = v.upc[5:2];
            if (v.ut && m_pht[idx] != 2'b11) m_pht[idx] = m_pht[idx] + 2'b01;
            if (!v.ut && m_pht[idx] != 2'b00) m_pht[idx] = m_pht[idx] - 2'b01;
            m_bhr = {m_bhr[6:0], v.ut};
            if (v.ut) begin
                m_v[bi]   = 1'b1;
                m_tag[bi] = v.upc[31:6];
                m_tgt[bi] = v.utgt;
            end
        end
    endtask

    task automatic apply(vec_t v, int id, bit use_model);
        exp_t e;
        @(negedge clk);
        reset      = v.rst;
        fe_pc      = v.fe;
        upd_valid  = v.uv;
        upd_taken  = v.ut;
        upd_pc     = v.upc;
        upd_target = v.utgt;
        upd_bhr    = v.ubhr;
        if (v.chk) begin
            if (use_model) begin
                e = model_lookup(id, v.fe);
            end else begin
                e.id = id; e.t = v.et; e.tgt = v.etgt; e.bhr = v.ebhr;
            end
            sb.push_back(e);
        end
        #2;
        if (v.chk && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (pred_taken !== e.t) begin
                errors++;
                $display("FAIL taken[%0d] fe=%h got %b want %b",
                         e.id, v.fe, pred_taken, e.t);
            end
            checks++;
            if (pred_target !== e.tgt) begin
                errors++;
                $display("FAIL target[%0d] fe=%h got %h want %h",
                         e.id, v.fe, pred_target, e.tgt);
            end
            checks++;
            if (pred_bhr !== e.bhr) begin
                errors++;
                $display("FAIL bhr[%0d] fe=%h got %h want %h",
                         e.id, v.fe, pred_bhr, e.bhr);
            end
        end
        @(posedge clk);
        model_update(v);
    endtask

    initial begin
        reset = 1'b1; fe_pc = '0; upd_valid = 1'b0; upd_taken = 1'b0;
        upd_pc = '0; upd_target = '0; upd_bhr = '0;
        m_bhr = '0;

        // Reset with a pending update, then train-and-predict.
        tbl.push_back(mk(1, 32'h100, 1, 1, 32'h100, 32'h80, 8'h01, 0, 0, 0, 0));
        tbl.push_back(lk(32'h100, 0, 32'h104, 8'h00));
        tbl.push_back(up(32'h100, 1, 32'h100, 32'h80, 8'h01, 0, 32'h104, 8'h00));
        tbl.push_back(lk(32'h100, 1, 32'h80, 8'h01));
        // Saturation.
        tbl.push_back(up(32'h100, 1, 32'h100, 32'h80, 8'h01, 1, 32'h80, 8'h01));
        tbl.push_back(up(32'h100, 1, 32'h100, 32'h80, 8'h01, 0, 32'h104, 8'h03));
        tbl.push_back(up(32'h104, 0, 32'h100, 32'h80, 8'h01, 0, 32'h108, 8'h07));
        tbl.push_back(up(32'h200, 0, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'h0E));
        tbl.push_back(up(32'h200, 0, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'h1C));
        tbl.push_back(up(32'h200, 0, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'h38));
        tbl.push_back(up(32'h200, 0, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'h70));
        tbl.push_back(up(32'h200, 0, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'hE0));
        tbl.push_back(up(32'h200, 0, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'hC0));
        tbl.push_back(up(32'h200, 0, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'h80));
        tbl.push_back(up(32'h200, 1, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'h00));
        tbl.push_back(lk(32'h100, 1, 32'h80, 8'h01));
        tbl.push_back(up(32'h100, 0, 32'h100, 32'h80, 8'h01, 1, 32'h80, 8'h01));
        tbl.push_back(up(32'h200, 0, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'h02));
        tbl.push_back(up(32'h200, 0, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'h04));
        tbl.push_back(up(32'h200, 0, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'h08));
        tbl.push_back(up(32'h200, 0, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'h10));
        tbl.push_back(up(32'h200, 0, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'h20));
        tbl.push_back(up(32'h200, 0, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'h40));
        tbl.push_back(up(32'h200, 0, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'h80));
        tbl.push_back(up(32'h200, 1, 32'h3C, 32'h300, 8'h00, 0, 32'h204, 8'h00));
        tbl.push_back(lk(32'h100, 0, 32'h104, 8'h01));
        // Alias: 0x140 shares BTB slot 0 with 0x100.
        tbl.push_back(up(32'h100, 1, 32'h144, 32'h400, 8'h06, 0, 32'h104, 8'h01));
        tbl.push_back(up(32'h144, 1, 32'h144, 32'h400, 8'h06, 0, 32'h148, 8'h03));
        tbl.push_back(lk(32'h140, 0, 32'h144, 8'h07));
        tbl.push_back(up(32'h140, 1, 32'h140, 32'h200, 8'h0F, 0, 32'h144, 8'h07));
        tbl.push_back(lk(32'h140, 1, 32'h200, 8'h0F));
        tbl.push_back(up(32'h100, 1, 32'h3C, 32'h300, 8'h00, 0, 32'h104, 8'h0F));
        tbl.push_back(lk(32'h100, 0, 32'h104, 8'h1F));
        // Reset mid-stream, retrain, reset again.
        tbl.push_back(mk(1, 32'h100, 1, 1, 32'h100, 32'h80, 8'h01, 1, 0, 32'h104, 8'h1F));
        tbl.push_back(up(32'h100, 1, 32'h100, 32'h80, 8'h01, 0, 32'h104, 8'h00));
        tbl.push_back(lk(32'h100, 1, 32'h80, 8'h01));
        tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h80, 8'h01));
        tbl.push_back(lk(32'h100, 0, 32'h104, 8'h00));
        tbl.push_back(lk(32'hFFFFFFFC, 0, 32'h0, 8'h00));
        // upd_valid low with taken high must not train.
        tbl.push_back(mk(0, 32'h100, 0, 1, 32'h100, 32'h80, 8'h01, 1, 0, 32'h104, 8'h00));
        tbl.push_back(lk(32'h100, 0, 32'h104, 8'h00));

        foreach (tbl[i]) apply(tbl[i], i, 1'b0);

        for (int n = 0; n < 400; n++) begin
            vec_t        v;
            logic [31:0] pcs [6];
            pcs[0] = 32'h100; pcs[1] = 32'h140; pcs[2] = 32'h104;
            pcs[3] = 32'h3C;  pcs[4] = 32'h180;
            pcs[5] = {$urandom_range(0, 255), 2'b00};
            v.rst  = ($urandom_range(0, 63) == 0);
            v.fe   = pcs[$urandom_range(0, 5)];
            v.uv   = ($urandom_range(0, 3) != 0);
            v.ut   = ($urandom_range(0, 2) != 0);
            v.upc  = pcs[$urandom_range(0, 5)];
            v.utgt = {$urandom_range(0, 4095), 2'b00};
            v.ubhr = (v.upc[9:2] ^ m_bhr) ^ 8'($urandom_range(0, 1));
            v.chk  = 1'b1;
            v.et   = 1'b0; v.etgt = '0; v.ebhr = '0;
            apply(v, 1000 + n, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
